// File: rtl/morph_pkg.sv
// Shared constants and helpers for the 3x3 binary morphology filter.
// Mode encoding, default frame geometry and video-counter widths.
package morph_pkg;

  localparam int H_ACTIVE_DEF = 640;
  localparam int V_ACTIVE_DEF = 480;

  localparam int HCNT_W = 12;
  localparam int VCNT_W = 11;

  typedef enum logic [1:0] {
    MODE_BYPASS = 2'd0,
    MODE_ERODE  = 2'd1,
    MODE_DILATE = 2'd2,
    MODE_MAJ    = 2'd3
  } mode_e;

  function automatic logic [3:0] popcnt9(
    input logic [8:0] w
  );
    logic [3:0] cnt;
    cnt = 4'd0;
    for (int i = 0; i < 9; i++) begin
      cnt = cnt + 4'(w[i]);
    end
    return cnt;
  endfunction

endpackage

// File: rtl/line_buffer_1b.sv
// Single-port 1-bit line memory, read-before-write.
// Read is combinational on the address; write lands at the clock edge.
module line_buffer_1b #(
  parameter int DEPTH = 640,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] addr_i,
  input  logic          wdata_i,
  output logic          rdata_o
);

  logic mem_q [DEPTH];

  assign rdata_o = mem_q[addr_i];

  // Contents are not reset; stale data is masked downstream.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
  end

endmodule

// File: rtl/binary_morph.sv
// 3x3 erode / dilate / majority filter on the 1-bit colour mask.
// Output for pixel (h-1, v-1) is registered one clock after (h, v).
module binary_morph
  import morph_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF
) (
  input  logic              PClk,
  input  logic              RstN,
  input  logic [1:0]        Mode,
  input  logic [HCNT_W-1:0] VtcHCnt,
  input  logic [VCNT_W-1:0] VtcVCnt,
  input  logic              BinIn,
  output logic              BinOut,
  output logic [HCNT_W-1:0] BinHCnt,
  output logic [VCNT_W-1:0] BinVCnt,
  output logic              BinValid
);

  localparam int AW =
    (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;

  localparam logic [HCNT_W-1:0] HA =
    HCNT_W'(H_ACTIVE);
  localparam logic [VCNT_W-1:0] VA =
    VCNT_W'(V_ACTIVE);
  localparam logic [HCNT_W-1:0] H1 =
    HCNT_W'(1);
  localparam logic [VCNT_W-1:0] V1 =
    VCNT_W'(1);

  logic          h_act;
  logic          v_act;
  logic          v_rgn;
  logic          s;
  logic          lb_we;
  logic [AW-1:0] lb_addr;
  logic          l0_rd;
  logic          l1_rd;

  logic [2:0]    col_new;
  logic [2:0]    col_mid_q;
  logic [2:0]    col_left_q;
  logic [2:0]    col_left;
  logic [2:0]    row_top;
  logic [2:0]    row_mid;
  logic [2:0]    row_bot;
  logic [8:0]    win;
  logic [3:0]    pop;
  logic          cen_vld;
  logic          res;
  logic          frame_start;

  mode_e         mode_q;
  mode_e         mode_d;

  logic              out_q;
  logic              out_d;
  logic              vld_q;
  logic              vld_d;
  logic [HCNT_W-1:0] hcnt_q;
  logic [HCNT_W-1:0] hcnt_d;
  logic [VCNT_W-1:0] vcnt_q;
  logic [VCNT_W-1:0] vcnt_d;

  assign h_act = (VtcHCnt < HA);
  assign v_act = (VtcVCnt < VA);
  assign v_rgn = (VtcVCnt <= VA);

  // Outside the image the sample is 0.
  assign s = BinIn & h_act & v_act;

  // Buffers advance on every active column of
  // the processing rows, including the extra row.
  assign lb_we = h_act & v_rgn;

  assign lb_addr =
    h_act ? VtcHCnt[AW-1:0] : '0;

  line_buffer_1b #(
    .DEPTH (H_ACTIVE),
    .AW    (AW)
  ) u_l0 (
    .clk_i   (PClk),
    .we_i    (lb_we),
    .addr_i  (lb_addr),
    .wdata_i (s),
    .rdata_o (l0_rd)
  );

  line_buffer_1b #(
    .DEPTH (H_ACTIVE),
    .AW    (AW)
  ) u_l1 (
    .clk_i   (PClk),
    .we_i    (lb_we),
    .addr_i  (lb_addr),
    .wdata_i (l0_rd),
    .rdata_o (l1_rd)
  );

  // Right column: bit2 = row v-2, bit1 = v-1,
  // bit0 = v. Zero from h == H_ACTIVE onward.
  assign col_new =
    h_act ? {l1_rd, l0_rd, s} : 3'b000;

  // Column shift: new -> middle -> left.
  always_ff @(posedge PClk or negedge RstN) begin
    if (!RstN) begin
      col_mid_q  <= 3'b000;
      col_left_q <= 3'b000;
    end else begin
      col_mid_q  <= col_new;
      col_left_q <= col_mid_q;
    end
  end

  assign col_left =
    (VtcHCnt == H1) ? 3'b000 : col_left_q;

  assign row_top =
    {col_left[2], col_mid_q[2], col_new[2]}
    & {3{VtcVCnt != V1}};

  assign row_mid =
    {col_left[1], col_mid_q[1], col_new[1]};

  assign row_bot =
    {col_left[0], col_mid_q[0], col_new[0]}
    & {3{VtcVCnt != VA}};

  assign win = {row_top, row_mid, row_bot};
  assign pop = popcnt9(win);

  assign cen_vld =
    (VtcHCnt >= H1) && (VtcHCnt <= HA) &&
    (VtcVCnt >= V1) && (VtcVCnt <= VA);

  assign frame_start =
    (VtcHCnt == '0) && (VtcVCnt == '0);

  // Filter kernel selected by the frame mode.
  always_comb begin
    res = 1'b0;
    unique case (mode_q)
      MODE_BYPASS: res = row_mid[1];
      MODE_ERODE:  res = &win;
      MODE_DILATE: res = |win;
      MODE_MAJ:    res = (pop >= 4'd5);
    endcase
  end

  // Mode only changes at the frame origin.
  always_comb begin
    mode_d = mode_q;
    if (frame_start) begin
      mode_d = mode_e'(Mode);
    end
  end

  // Next output word; zero when centre invalid.
  always_comb begin
    vld_d  = cen_vld;
    out_d  = res & cen_vld;
    hcnt_d = '0;
    vcnt_d = '0;
    if (cen_vld) begin
      hcnt_d = VtcHCnt - H1;
      vcnt_d = VtcVCnt - V1;
    end
  end

  // Mode and output registers.
  always_ff @(posedge PClk or negedge RstN) begin
    if (!RstN) begin
      mode_q <= MODE_BYPASS;
      out_q  <= 1'b0;
      vld_q  <= 1'b0;
      hcnt_q <= '0;
      vcnt_q <= '0;
    end else begin
      mode_q <= mode_d;
      out_q  <= out_d;
      vld_q  <= vld_d;
      hcnt_q <= hcnt_d;
      vcnt_q <= vcnt_d;
    end
  end

  assign BinOut   = out_q;
  assign BinValid = vld_q;
  assign BinHCnt  = hcnt_q;
  assign BinVCnt  = vcnt_q;

endmodule

// File: tb/tb_binary_morph.sv
// Randomised bench for binary_morph on a reduced frame.
// Reference: direct 3x3 neighbourhood over a stored frame image.
module tb_binary_morph;

  localparam int HA = 32;
  localparam int VA = 24;
  localparam int HT = HA + 4;
  localparam int VT = VA + 3;

  localparam logic [1:0] BYP = 2'd0;
  localparam logic [1:0] ERO = 2'd1;
  localparam logic [1:0] DIL = 2'd2;
  localparam logic [1:0] MAJ = 2'd3;

  logic        PClk;
  logic        RstN;
  logic [1:0]  Mode;
  logic [11:0] VtcHCnt;
  logic [10:0] VtcVCnt;
  logic        BinIn;
  logic        BinOut;
  logic [11:0] BinHCnt;
  logic [10:0] BinVCnt;
  logic        BinValid;

  binary_morph #(
    .H_ACTIVE (HA),
    .V_ACTIVE (VA)
  ) dut (
    .PClk     (PClk),
    .RstN     (RstN),
    .Mode     (Mode),
    .VtcHCnt  (VtcHCnt),
    .VtcVCnt  (VtcVCnt),
    .BinIn    (BinIn),
    .BinOut   (BinOut),
    .BinHCnt  (BinHCnt),
    .BinVCnt  (BinVCnt),
    .BinValid (BinValid)
  );

  initial PClk = 1'b0;
  always #5 PClk = ~PClk;

  int n_vec = 0;
  int n_err = 0;

  logic       img [VA][HA];
  logic [1:0] mode_m = 2'd0;
  logic       chk_en = 1'b0;
  int         sw_v = -1;
  logic [1:0] sw_md = 2'd0;
  int         rst_h = -1;
  int         rst_v = -1;
  int         rst_cnt = 0;

  task automatic chk(
    input string       tag,
    input logic [24:0] got,
    input logic [24:0] exp
  );
    n_vec++;
    if (got !== exp) begin
      n_err++;
      if (n_err <= 30)
        $display("FAIL %s got v%0b o%0b x%0d y%0d exp v%0b o%0b x%0d y%0d",
                 tag, got[24], got[23], got[22:11], got[10:0],
                 exp[24], exp[23], exp[22:11], exp[10:0]);
    end
  endtask

  function automatic logic ref_pix(
    input logic [1:0] md,
    input int         x,
    input int         y
  );
    int n;
    int xx;
    int yy;
    n = 0;
    for (int dy = -1; dy <= 1; dy++) begin
      for (int dx = -1; dx <= 1; dx++) begin
        xx = x + dx;
        yy = y + dy;
        if (xx >= 0 && xx < HA && yy >= 0 && yy < VA)
          if (img[yy][xx]) n++;
      end
    end
    case (md)
      BYP:     return img[y][x];
      ERO:     return (n == 9);
      DIL:     return (n > 0);
      default: return (n >= 5);
    endcase
  endfunction

  function automatic logic gen(
    input int kind,
    input int dens,
    input int h,
    input int v
  );
    if (h >= HA || v >= VA)
      return 1'($urandom_range(1, 0));
    case (kind)
      0: return ($urandom_range(7, 0) < dens);
      1: return (h == 12 && v == 8);
      2: return 1'b1;
      default:
        return ((h >= 20 && h <= 22 &&
                 v >= 15 && v <= 17) ||
                (h == 4 && v == 4));
    endcase
  endfunction

  task automatic step(
    input int   h,
    input int   v,
    input logic b
  );
    logic [24:0] exp;
    logic        rstd;
    VtcHCnt = 12'(h);
    VtcVCnt = 11'(v);
    BinIn   = b;
    if (h < HA && v < VA) img[v][h] = b;
    rstd = !RstN;
    exp = '0;
    if (!rstd && h >= 1 && h <= HA &&
        v >= 1 && v <= VA)
      exp = {1'b1, ref_pix(mode_m, h - 1, v - 1),
             12'(h - 1), 11'(v - 1)};
    if (rstd) begin
      mode_m = BYP;
    end else if (h == 0 && v == 0) begin
      mode_m = Mode;
      chk_en = 1'b1;
    end
    @(posedge PClk);
    #1;
    if (chk_en || rstd)
      chk("pix", {BinValid, BinOut, BinHCnt, BinVCnt},
          exp);
  endtask

  task automatic frame(
    input int         kind,
    input int         dens,
    input logic [1:0] md
  );
    Mode = md;
    for (int v = 0; v < VT; v++) begin
      for (int h = 0; h < HT; h++) begin
        if (v == sw_v && h == 0) Mode = sw_md;
        step(h, v, gen(kind, dens, h, v));
        if (h == rst_h && v == rst_v) begin
          #2 RstN = 1'b0;
          #1;
          chk("rst_async",
              {BinValid, BinOut, BinHCnt, BinVCnt}, '0);
          chk_en  = 1'b0;
          rst_cnt = 6;
        end else if (rst_cnt > 0) begin
          rst_cnt--;
          if (rst_cnt == 0) RstN = 1'b1;
        end
      end
    end
  endtask

  initial begin
    RstN    = 1'b0;
    Mode    = BYP;
    VtcHCnt = 12'(HT - 1);
    VtcVCnt = 11'(VT - 1);
    BinIn   = 1'b0;
    #1;
    chk("reset", {BinValid, BinOut, BinHCnt, BinVCnt}, '0);
    repeat (3) @(posedge PClk);
    #1;
    chk("reset_hold",
        {BinValid, BinOut, BinHCnt, BinVCnt}, '0);
    RstN = 1'b1;

    frame(0, 4, BYP);
    frame(0, 4, BYP);

    frame(1, 0, DIL);
    frame(1, 0, ERO);
    frame(1, 0, MAJ);

    frame(2, 0, ERO);

    frame(3, 0, MAJ);
    frame(3, 0, ERO);

    sw_v  = VA / 2;
    sw_md = DIL;
    frame(0, 4, BYP);
    sw_v  = -1;
    frame(0, 4, DIL);

    frame(0, 7, ERO);
    frame(0, 2, DIL);
    frame(0, 4, MAJ);
    frame(0, 6, MAJ);

    rst_h = 16;
    rst_v = 12;
    frame(0, 4, MAJ);
    rst_h = -1;
    rst_v = -1;
    frame(0, 4, MAJ);
    frame(0, 5, DIL);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
